// File: rtl/blink_pkg.sv
// Shared types and constants for the Blink round engine.
package blink_pkg;

    typedef enum logic [1:0] {
        ST_OFF,
        ST_ON,
        ST_HOLD,
        ST_DONE
    } state_t;

    localparam logic [3:0] SCORE_MAX = 4'd10;
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    // One step of the right-shifting Galois LFSR used to jitter the OFF gap.
    function automatic logic [7:0] lfsr_step(input logic [7:0] cur);
        return cur[0] ? ((cur >> 1) ^ LFSR_TAPS) : (cur >> 1);
    endfunction

    function automatic logic [3:0] score_inc(input logic [3:0] cur);
        return (cur >= SCORE_MAX) ? SCORE_MAX : cur + 4'd1;
    endfunction

endpackage

// File: rtl/blink_tick_gen.sv
// Game-tick prescaler: one-cycle tick every TICK_DIV clocks while run is high,
// counter parked at zero while run is low.
module blink_tick_gen #(
    parameter int TICK_DIV = 100000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic run,
    output logic tick
);

    localparam int              CW   = $clog2(TICK_DIV);
    localparam logic [CW-1:0]   LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (!run || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = run && (cnt == LAST);

endmodule

// File: rtl/blink_round.sv
// Blink round engine: timed LED window, hit scoring, miss/false-press detection.
// Define BLINK_LFSR_EN to stretch each OFF gap by a pseudo-random 0..7 ticks.
module blink_round
    import blink_pkg::*;
#(
    parameter int TICK_DIV      = 100000,
    parameter int ON_TICKS_BASE = 12,
    parameter int OFF_TICKS     = 6
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       btn,
    input  logic       end_cond,
    output logic       led,
    output logic [3:0] x,
    output logic       lose
);

    localparam int WW      = $clog2(ON_TICKS_BASE) + 1;
    localparam int OFF_MAX = OFF_TICKS + 7;
    localparam int TMAX    = (ON_TICKS_BASE > OFF_MAX) ? ON_TICKS_BASE : OFF_MAX;
    localparam int TW      = $clog2(TMAX + 1);

    state_t        state, state_nxt;
    logic [3:0]    x_nxt;
    logic          lose_nxt;
    logic          sync1, sync2, sync2_d, press;
    logic          tick;
    logic [TW-1:0] timer, timer_inc, off_len;
    logic [WW-1:0] window;

    blink_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .clk    (clk),
        .reset_n(reset_n),
        .run    (state != ST_DONE),
        .tick   (tick)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            sync2_d <= 1'b0;
            press   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep each flop a separate stage; blocking ones would collapse the chain into a wire.
            sync1   <= btn;
            sync2   <= sync1;
            sync2_d <= sync2;
            press   <= sync2 & ~sync2_d;
        end
    end

`ifdef BLINK_LFSR_EN
    logic [7:0] lfsr;

    // The gap length is latched on entry so a tick mid-gap cannot move the goalpost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr    <= LFSR_SEED;
            off_len <= TW'(OFF_TICKS) + TW'(LFSR_SEED[2:0]);
        end else begin
            if (tick) begin
                lfsr <= lfsr_step(lfsr);
            end
            if (state_nxt == ST_OFF && state != ST_OFF) begin
                off_len <= TW'(OFF_TICKS) + TW'(lfsr[2:0]);
            end
        end
    end
`else
    assign off_len = TW'(OFF_TICKS);
`endif

    assign window    = WW'(ON_TICKS_BASE) - WW'(x);
    assign timer_inc = timer + 1'b1;

    always_comb begin
        // NOTE: every output gets a default before the case, so no path can leave one unassigned and infer a latch.
        state_nxt = state;
        x_nxt     = x;
        lose_nxt  = 1'b0;
        if (end_cond) begin
            state_nxt = ST_DONE;
        end else begin
            case (state)
                ST_OFF: begin
                    if (press) begin
                        state_nxt = ST_DONE;
                        lose_nxt  = 1'b1;
                    end else if (tick && timer_inc == off_len) begin
                        state_nxt = ST_ON;
                    end
                end
                ST_ON: begin
                    // A press on the expiry cycle still scores: it is checked first.
                    if (press) begin
                        state_nxt = ST_HOLD;
                        x_nxt     = score_inc(x);
                    end else if (tick && timer_inc == TW'(window)) begin
                        state_nxt = ST_DONE;
                        lose_nxt  = 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (!sync2) begin
                        state_nxt = ST_OFF;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_OFF;
            timer <= '0;
            led   <= 1'b0;
            x     <= '0;
            lose  <= 1'b0;
        end else begin
            state <= state_nxt;
            led   <= (state_nxt == ST_ON);
            x     <= x_nxt;
            lose  <= lose_nxt;
            if (state_nxt != state) begin
                timer <= '0;
            end else if (tick) begin
                timer <= timer_inc;
            end
        end
    end

endmodule

// File: tb/tb_blink_round.sv
// Self-checking bench for blink_round (TICK_DIV=4, ON_TICKS_BASE=12, OFF_TICKS=3)
// against a countdown-style behavioural model of the round rules.
`timescale 1ns/1ps
module tb_blink_round;

    localparam int TICK_DIV = 4;
    localparam int ON_BASE  = 12;
    localparam int OFF_T    = 3;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       btn = 1'b0;
    logic       end_cond = 1'b0;
    logic       led;
    logic       lose;
    logic [3:0] x;

    blink_round #(
        .TICK_DIV     (TICK_DIV),
        .ON_TICKS_BASE(ON_BASE),
        .OFF_TICKS    (OFF_T)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .btn     (btn),
        .end_cond(end_cond),
        .led     (led),
        .x       (x),
        .lose    (lose)
    );

    always #5 clk = ~clk;

    typedef enum {M_DARK, M_LIT, M_WAIT, M_OVER} mode_t;

    mode_t m_mode;
    int    m_score;
    int    m_left;      // ticks remaining in the current dark/lit phase
    int    m_presc;     // cycles since the last game tick
    bit    m_lose;
    bit    btn_hist[$]; // btn sampled at previous edges, newest first

    int n_checks = 0;
    int n_pass   = 0;
    int lose_seen;

    function automatic void model_reset();
        m_mode    = M_DARK;
        m_score   = 0;
        m_left    = OFF_T;
        m_presc   = 0;
        m_lose    = 1'b0;
        btn_hist  = '{1'b0, 1'b0, 1'b0, 1'b0};
    endfunction

    function automatic bit exp_led();
        return m_mode == M_LIT;
    endfunction

    // Effect of one rising edge; b/e are the btn/end_cond values sampled there.
    function automatic void model_edge(input bit b, input bit e);
        bit pressed, held, tick;
        pressed = btn_hist[2] && !btn_hist[3];   // 3-edge button latency
        held    = btn_hist[1];
        tick    = (m_mode != M_OVER) && (m_presc == TICK_DIV - 1);
        m_presc = (m_mode == M_OVER || tick) ? 0 : m_presc + 1;
        m_lose  = 1'b0;
        if (e) begin
            m_mode = M_OVER;
        end else begin
            case (m_mode)
                M_DARK: begin
                    if (pressed) begin
                        m_mode = M_OVER;
                        m_lose = 1'b1;
                    end else if (tick) begin
                        m_left--;
                        if (m_left == 0) begin
                            m_mode = M_LIT;
                            m_left = ON_BASE - m_score;
                        end
                    end
                end
                M_LIT: begin
                    if (pressed) begin
                        m_score = (m_score < 10) ? m_score + 1 : 10;
                        m_mode  = M_WAIT;
                    end else if (tick) begin
                        m_left--;
                        if (m_left == 0) begin
                            m_mode = M_OVER;
                            m_lose = 1'b1;
                        end
                    end
                end
                M_WAIT: begin
                    if (!held) begin
                        m_mode = M_DARK;
                        m_left = OFF_T;
                    end
                end
                default: begin
                end
            endcase
        end
        btn_hist.push_front(b);
        void'(btn_hist.pop_back());
    endfunction

    // Drive inputs, advance one clock, update the model, land on the falling edge.
    task automatic step(input bit b, input bit e);
        btn      = b;
        end_cond = e;
        @(posedge clk);
        model_edge(b, e);
        @(negedge clk);
        if (lose === 1'b1) lose_seen++;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        btn      = 1'b0;
        end_cond = 1'b0;
        reset_n  = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        reset_n   = 1'b1;
        lose_seen = 0;
    endtask

    // Stimulus only: wait for the LED, then press and release inside the window.
    task automatic play_hit();
        int budget = 120;
        while (m_mode != M_LIT && budget > 0) begin
            step(1'b0, 1'b0);
            budget--;
        end
        repeat ($urandom_range(0, 2)) step(1'b0, 1'b0);
        repeat (3) step(1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b0);
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset_n = 1'b0;
        btn     = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        n_checks++;
        if (led !== 1'b0 || x !== 4'd0 || lose !== 1'b0)
            $display("FAIL reset_values: got led=%b x=%0d lose=%b, want led=0 x=0 lose=0", led, x, lose);
        else n_pass++;
        btn = 1'b0;
        @(negedge clk);
        reset_n   = 1'b1;
        lose_seen = 0;
    endtask

    task automatic test_idle();
        int first_led = -1;
        int led_cycles = 0;
        apply_reset();
        for (int c = 1; c <= 80; c++) begin
            step(1'b0, 1'b0);
            n_checks++;
            if (led !== exp_led() || x !== 4'(m_score) || lose !== m_lose)
                $display("FAIL idle c%0d: got led=%b x=%0d lose=%b, want led=%b x=%0d lose=%b",
                         c, led, x, lose, exp_led(), m_score, m_lose);
            else n_pass++;
            if (led === 1'b1) begin
                led_cycles++;
                if (first_led < 0) first_led = c;
            end
        end
        n_checks++;
        if (first_led != 12) $display("FAIL idle_led_rise: got cycle %0d, want 12", first_led);
        else n_pass++;
        n_checks++;
        if (led_cycles != 48) $display("FAIL idle_window_len: got %0d cycles, want 48", led_cycles);
        else n_pass++;
        n_checks++;
        if (lose_seen != 1 || x !== 4'd0)
            $display("FAIL idle_end: got lose pulses=%0d x=%0d, want 1 and 0", lose_seen, x);
        else n_pass++;
    endtask

    task automatic test_hold_press();
        int budget = 60;
        int led_cycles = 0;
        int x_changes = 0;
        logic [3:0] prev_x = 4'd0;
        apply_reset();
        while (m_mode != M_LIT && budget > 0) begin
            step(1'b0, 1'b0);
            budget--;
        end
        repeat ($urandom_range(0, 20)) step(1'b0, 1'b0);
        for (int c = 0; c < 128; c++) begin
            step((c < 8) ? 1'b1 : 1'b0, 1'b0);
            n_checks++;
            if (led !== exp_led() || x !== 4'(m_score) || lose !== m_lose)
                $display("FAIL hold c%0d: got led=%b x=%0d lose=%b, want led=%b x=%0d lose=%b",
                         c, led, x, lose, exp_led(), m_score, m_lose);
            else n_pass++;
            if (x !== prev_x) x_changes++;
            prev_x = x;
            if (c == 7) begin
                n_checks++;
                if (led !== 1'b0 || x !== 4'd1)
                    $display("FAIL hold_while_held: got led=%b x=%0d, want led=0 x=1", led, x);
                else n_pass++;
            end
            if (c >= 8 && led === 1'b1) led_cycles++;
        end
        n_checks++;
        if (x_changes != 1) $display("FAIL hold_single_score: got %0d score changes, want 1", x_changes);
        else n_pass++;
        n_checks++;
        if (led_cycles != 44) $display("FAIL hold_second_window: got %0d cycles, want 44", led_cycles);
        else n_pass++;
        n_checks++;
        if (lose_seen != 1) $display("FAIL hold_miss: got %0d lose pulses, want 1", lose_seen);
        else n_pass++;
    endtask

    task automatic test_false_press();
        for (int v = 0; v < 2; v++) begin
            int budget = 60;
            int led_cycles = 0;
            apply_reset();
            if (v == 1) begin
                play_hit();
                while (m_mode != M_DARK && budget > 0) begin
                    step(1'b0, 1'b0);
                    budget--;
                end
                lose_seen = 0;
                step(1'b0, 1'b0);
            end else begin
                repeat ($urandom_range(1, 6)) step(1'b0, 1'b0);
            end
            for (int c = 0; c < 24; c++) begin
                step((c < 2) ? 1'b1 : 1'b0, 1'b0);
                n_checks++;
                if (led !== exp_led() || x !== 4'(m_score) || lose !== m_lose)
                    $display("FAIL false_press v%0d c%0d: got led=%b x=%0d lose=%b, want led=%b x=%0d lose=%b",
                             v, c, led, x, lose, exp_led(), m_score, m_lose);
                else n_pass++;
                if (led === 1'b1) led_cycles++;
            end
            n_checks++;
            if (lose_seen != 1 || led_cycles != 0 || x !== 4'(v))
                $display("FAIL false_press_result v%0d: got lose pulses=%0d led cycles=%0d x=%0d, want 1, 0, %0d",
                         v, lose_seen, led_cycles, x, v);
            else n_pass++;
        end
    endtask

    task automatic test_ten_hits();
        apply_reset();
        for (int h = 1; h <= 11; h++) begin
            play_hit();
            n_checks++;
            if (x !== 4'((h > 10) ? 10 : h))
                $display("FAIL hit%0d_score: got %0d, want %0d", h, x, (h > 10) ? 10 : h);
            else n_pass++;
        end
        n_checks++;
        if (lose_seen != 0) $display("FAIL hits_no_lose: got %0d lose pulses, want 0", lose_seen);
        else n_pass++;
        // end_cond lands on the same edge as a press: it must neither score nor lose.
        begin
            int budget = 60;
            while (m_mode != M_LIT && budget > 0) begin
                step(1'b0, 1'b0);
                budget--;
            end
        end
        repeat (3) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        for (int c = 0; c < 40; c++) begin
            step(1'($urandom_range(0, 1)), 1'b0);
            n_checks++;
            if (led !== 1'b0 || x !== 4'd10 || lose !== 1'b0 || led !== exp_led() || lose !== m_lose)
                $display("FAIL end_cond_frozen c%0d: got led=%b x=%0d lose=%b, want led=0 x=10 lose=0",
                         c, led, x, lose);
            else n_pass++;
        end
        n_checks++;
        if (lose_seen != 0) $display("FAIL end_cond_no_lose: got %0d lose pulses, want 0", lose_seen);
        else n_pass++;
    endtask

    task automatic test_coincident();
        int budget = 80;
        apply_reset();
        while (!(m_mode == M_LIT && m_left == 1 && m_presc == 0) && budget > 0) begin
            step(1'b0, 1'b0);
            budget--;
        end
        n_checks++;
        if (budget == 0) $display("FAIL coincident_setup: got timeout, want last window tick");
        else n_pass++;
        for (int c = 0; c < 12; c++) begin
            step((c < 4) ? 1'b1 : 1'b0, 1'b0);
            n_checks++;
            if (led !== exp_led() || x !== 4'(m_score) || lose !== m_lose)
                $display("FAIL coincident c%0d: got led=%b x=%0d lose=%b, want led=%b x=%0d lose=%b",
                         c, led, x, lose, exp_led(), m_score, m_lose);
            else n_pass++;
        end
        n_checks++;
        if (x !== 4'd1 || lose_seen != 0)
            $display("FAIL coincident_result: got x=%0d lose pulses=%0d, want x=1 and 0", x, lose_seen);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        int budget = 80;
        int first_led = -1;
        apply_reset();
        repeat (5) play_hit();
        n_checks++;
        if (x !== 4'd5) $display("FAIL async_setup_score: got %0d, want 5", x);
        else n_pass++;
        while (m_mode != M_LIT && budget > 0) begin
            step(1'b0, 1'b0);
            budget--;
        end
        repeat ($urandom_range(1, 10)) step(1'b0, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if (led !== 1'b0 || x !== 4'd0 || lose !== 1'b0)
            $display("FAIL async_reset: got led=%b x=%0d lose=%b, want led=0 x=0 lose=0", led, x, lose);
        else n_pass++;
        model_reset();
        repeat (2) @(negedge clk);
        reset_n   = 1'b1;
        lose_seen = 0;
        for (int c = 1; c <= 20; c++) begin
            step(1'b0, 1'b0);
            n_checks++;
            if (led !== exp_led() || x !== 4'(m_score) || lose !== m_lose)
                $display("FAIL async_restart c%0d: got led=%b x=%0d lose=%b, want led=%b x=%0d lose=%b",
                         c, led, x, lose, exp_led(), m_score, m_lose);
            else n_pass++;
            if (led === 1'b1 && first_led < 0) first_led = c;
        end
        n_checks++;
        if (first_led != 12) $display("FAIL async_restart_rise: got cycle %0d, want 12", first_led);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++) begin
            bit b = 1'b0;
            int hold_left = 0;
            apply_reset();
            for (int c = 0; c < 250; c++) begin
                if (hold_left == 0) begin
                    if (m_mode == M_LIT) b = ($urandom_range(0, 3) == 0);
                    else                 b = ($urandom_range(0, 39) == 0);
                    hold_left = $urandom_range(1, 10);
                end
                hold_left--;
                step(b, $urandom_range(0, 199) == 0);
                n_checks++;
                if (led !== exp_led() || x !== 4'(m_score) || lose !== m_lose)
                    $display("FAIL random r%0d c%0d: got led=%b x=%0d lose=%b, want led=%b x=%0d lose=%b",
                             r, c, led, x, lose, exp_led(), m_score, m_lose);
                else n_pass++;
            end
        end
    endtask

    initial begin
        model_reset();
        lose_seen = 0;
        test_reset();
        test_idle();
        test_hold_press();
        test_false_press();
        test_ten_hits();
        test_coincident();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion, want finish before 2 ms");
        $fatal(1, "watchdog expired");
    end

endmodule
